// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with pending-write scoreboard.
package regfile_pkg;

    localparam int ZERO_REG       = 0;
    localparam int A0_REG         = 10;
    localparam int MAX_READ_PORTS = 4;
    localparam int REG_IDX_W      = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pending bit per register plus a registered
// popcount. Within a cycle, flush beats everything, then alloc (set) beats
// writeback (clear). x0 is never pending.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alloc_en,
    input  logic [ADDRESS_WIDTH-1:0]     alloc_addr,
    input  logic                         we,
    input  logic [ADDRESS_WIDTH-1:0]     wa,
    input  logic                         flush,
    output logic [(2**ADDRESS_WIDTH)-1:0] pending,
    output logic [ADDRESS_WIDTH:0]       busy_count
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(ZERO_REG);

    logic [DEPTH-1:0] pend_next;

    function automatic logic [ADDRESS_WIDTH:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDRESS_WIDTH:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{ADDRESS_WIDTH{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Next pending state: flush clears all, else writeback clears, alloc sets last
    always_comb begin
        pend_next = pending;
        if (flush) begin
            pend_next = '0;
        end else begin
            if (we && (wa != ZERO_IDX)) begin
                pend_next[wa] = 1'b0;
            end
            if (alloc_en && (alloc_addr != ZERO_IDX)) begin
                pend_next[alloc_addr] = 1'b1;
            end
        end
        pend_next[0] = 1'b0;
    end

    // Pending bits and their count update together from the same next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            busy_count <= '0;
        end else begin
            pending    <= pend_next;
            busy_count <= popcount(pend_next);
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// Integer register file with NUM_READ combinational read ports, one
// synchronous write port and a pending-write scoreboard for RAW stalls.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_READ      = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_READ-1:0]               rd_ready,
    input  logic                              alloc_en,
    input  logic [ADDRESS_WIDTH-1:0]          alloc_addr,
    input  logic                              we,
    input  logic [ADDRESS_WIDTH-1:0]          wa,
    input  logic [DATA_WIDTH-1:0]             wd,
    input  logic                              flush,
    output logic [ADDRESS_WIDTH:0]            busy_count,
    output logic [DATA_WIDTH-1:0]             a0
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(ZERO_REG);
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX   = ADDRESS_WIDTH'(A0_REG);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;

    regfile_scoreboard #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .we         (we),
        .wa         (wa),
        .flush      (flush),
        .pending    (pending),
        .busy_count (busy_count)
    );

    // Data array: cleared by reset, written on the edge when wa is not x0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != ZERO_IDX)) begin
            regs[wa] <= wd;
        end
    end

    assign a0 = regs[A0_IDX];

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] idx;
        logic [DATA_WIDTH-1:0]    data;
        logic                     rdy;

        assign idx = rd_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        // Read mux: x0 reads as zero and always ready; bypass overrides stored state
        always_comb begin
            data = regs[idx];
            rdy  = !pending[idx];
            if (idx == ZERO_IDX) begin
                data = '0;
                rdy  = 1'b1;
            end
`ifdef REGFILE_BYPASS_EN
            else if (we && (wa == idx)) begin
                data = wd;
                // A same-cycle reallocation keeps the operand outstanding
                rdy  = !(alloc_en && (alloc_addr == wa) && !flush);
            end
`endif
        end

        assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rd_ready[g] = rdy;
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb with two read ports.
module tb_register_file_sb;
    import regfile_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_ready;
    logic        alloc_en;
    reg_idx_t    alloc_addr;
    logic        we;
    reg_idx_t    wa;
    logic [31:0] wd;
    logic        flush;
    logic [5:0]  busy_count;
    logic [31:0] a0;

    int total = 0;
    int bad   = 0;

    register_file_sb #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(5), .NUM_READ(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_ready(rd_ready), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .we(we), .wa(wa), .wd(wd), .flush(flush), .busy_count(busy_count), .a0(a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        alloc_en;
        reg_idx_t    alloc_addr;
        logic        we;
        reg_idx_t    wa;
        logic [31:0] wd;
        logic        flush;
        reg_idx_t    ra0;
        reg_idx_t    ra1;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic [1:0]  e_rdy;
        logic [5:0]  e_busy;
        logic [31:0] e_a0;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        alloc_en = 1'b0; alloc_addr = '0; we = 1'b0; wa = '0; wd = '0; flush = 1'b0;
    endtask

    initial begin
        idle();
        rd_addr = '0;
        rst_n   = 1'b0;

        //            alloc   aaddr we  wa  wd            fl  ra0 ra1 e_d0          e_d1          rdy    busy e_a0
        vecs[0]  = '{1'b1, 5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd3,  5'd0,  32'h0,        32'h0,        2'b10, 6'd1, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        2'b11, 6'd0, 32'h0};
        vecs[2]  = '{1'b0, 5'd0,  1'b1, 5'd7,  32'h1234,     1'b0, 5'd7,  5'd3,  32'h1234,     32'hDEADBEEF, 2'b11, 6'd0, 32'h0};
        vecs[3]  = '{1'b1, 5'd8,  1'b1, 5'd8,  32'h55,       1'b0, 5'd8,  5'd3,  32'h55,       32'hDEADBEEF, 2'b10, 6'd1, 32'h0};
        vecs[4]  = '{1'b1, 5'd1,  1'b0, 5'd0,  32'h0,        1'b0, 5'd1,  5'd8,  32'h0,        32'h55,       2'b00, 6'd2, 32'h0};
        vecs[5]  = '{1'b1, 5'd2,  1'b0, 5'd0,  32'h0,        1'b0, 5'd2,  5'd1,  32'h0,        32'h0,        2'b00, 6'd3, 32'h0};
        vecs[6]  = '{1'b1, 5'd4,  1'b0, 5'd0,  32'h0,        1'b0, 5'd4,  5'd3,  32'h0,        32'hDEADBEEF, 2'b10, 6'd4, 32'h0};
        vecs[7]  = '{1'b1, 5'd5,  1'b1, 5'd10, 32'h99,       1'b1, 5'd5,  5'd10, 32'h0,        32'h99,       2'b11, 6'd0, 32'h99};
        vecs[8]  = '{1'b1, 5'd0,  1'b1, 5'd0,  32'hFFFF,     1'b0, 5'd0,  5'd10, 32'h0,        32'h99,       2'b11, 6'd0, 32'h99};
        vecs[9]  = '{1'b1, 5'd5,  1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd0,  32'h0,        32'h0,        2'b10, 6'd1, 32'h99};
        vecs[10] = '{1'b1, 5'd5,  1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd0,  32'h0,        32'h0,        2'b10, 6'd1, 32'h99};
        vecs[11] = '{1'b1, 5'd6,  1'b1, 5'd5,  32'hA5,       1'b0, 5'd5,  5'd6,  32'hA5,       32'h0,        2'b01, 6'd1, 32'h99};
        vecs[12] = '{1'b1, 5'd31, 1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 5'd6,  32'h0,        32'h0,        2'b00, 6'd2, 32'h99};

        // reset state
        #12;
        rd_addr = {5'd0, 5'd5};
        #1;
        chk("rst_d0", rd_data[31:0], 32'h0);
        chk("rst_d1", rd_data[63:32], 32'h0);
        chk("rst_rdy", {30'd0, rd_ready}, 32'h3);
        chk("rst_busy", {26'd0, busy_count}, 32'h0);
        chk("rst_a0", a0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            alloc_en = vecs[i].alloc_en; alloc_addr = vecs[i].alloc_addr;
            we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd; flush = vecs[i].flush;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            @(posedge clk);
            #1;
            idle();
            #1;
            chk($sformatf("v%0d_d0", i), rd_data[31:0], vecs[i].e_d0);
            chk($sformatf("v%0d_d1", i), rd_data[63:32], vecs[i].e_d1);
            chk($sformatf("v%0d_rdy", i), {30'd0, rd_ready}, {30'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_busy", i), {26'd0, busy_count}, {26'd0, vecs[i].e_busy});
            chk($sformatf("v%0d_a0", i), a0, vecs[i].e_a0);
        end

        // clear x31 at the top index: pending {6}
        @(negedge clk);
        we = 1'b1; wa = 5'd31; wd = 32'hFFFFFFFF; rd_addr = {5'd6, 5'd31};
        @(posedge clk); #1; idle(); #1;
        chk("x31_d0", rd_data[31:0], 32'hFFFFFFFF);
        chk("x31_rdy", {30'd0, rd_ready}, 32'h1);
        chk("x31_busy", {26'd0, busy_count}, 32'h1);

        // make x7 pending: pending {6,7}
        @(negedge clk);
        alloc_en = 1'b1; alloc_addr = 5'd7;
        @(posedge clk); #1; idle(); #1;
        chk("x7_busy", {26'd0, busy_count}, 32'h2);

        // same-cycle read during writeback to x7
        @(negedge clk);
        we = 1'b1; wa = 5'd7; wd = 32'hCAFE; rd_addr = {5'd0, 5'd7};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_d0", rd_data[31:0], 32'hCAFE);
        chk("byp_rdy0", {31'd0, rd_ready[0]}, 32'h1);
`else
        chk("byp_d0", rd_data[31:0], 32'h1234);
        chk("byp_rdy0", {31'd0, rd_ready[0]}, 32'h0);
`endif
        alloc_en = 1'b1; alloc_addr = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypa_d0", rd_data[31:0], 32'hCAFE);
`else
        chk("bypa_d0", rd_data[31:0], 32'h1234);
`endif
        chk("bypa_rdy0", {31'd0, rd_ready[0]}, 32'h0);
        @(posedge clk); #1; idle(); #1;
        chk("x7_post_d0", rd_data[31:0], 32'hCAFE);
        chk("x7_post_rdy", {31'd0, rd_ready[0]}, 32'h0);
        chk("x7_post_busy", {26'd0, busy_count}, 32'h2);

        // asynchronous reset in the middle of a write/alloc
        @(negedge clk);
        alloc_en = 1'b1; alloc_addr = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h1;
        rd_addr = {5'd6, 5'd10};
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_d0", rd_data[31:0], 32'h0);
        chk("arst_rdy", {30'd0, rd_ready}, 32'h3);
        chk("arst_busy", {26'd0, busy_count}, 32'h0);
        chk("arst_a0", a0, 32'h0);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        rd_addr = {5'd7, 5'd9};
        @(posedge clk); #1;
        chk("arst_x9", rd_data[31:0], 32'h0);
        chk("arst_x7", rd_data[63:32], 32'h0);
        chk("arst_rdy2", {30'd0, rd_ready}, 32'h3);
        chk("arst_busy2", {26'd0, busy_count}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
